regfile_mp: RTL and testbench
=============================

Name: regfile_mp

Overview:
Parametrised multi-port CPU register file, the successor to the single-write/dual-read file. It provides NUM_RD combinational read ports and NUM_WR write ports, an optional hardwired-zero register 0, optional write-to-read bypass, and a per-register pending scoreboard. It sits in the decode/writeback path of the pipelined core. Decode reads operands and busy flags; issue allocates destinations; writeback ports retire results.

Parameters:
DATA_W, 32, register width in bits
NUM_REGS, 32, number of architectural registers (power of 2, >=2)
NUM_RD, 2, number of read ports (1..4)
NUM_WR, 2, number of write ports (1..2)
ZERO_REG, 1, 1 = register 0 reads 0, ignores writes, never pending
BYPASS, 1, 1 = same-cycle write data forwarded to reads
(derived) AW = $clog2(NUM_REGS)

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous, active-high reset
rd_addr  in  NUM_RD*AW  read addresses, port i at [i*AW +: AW]
rd_data  out  NUM_RD*DATA_W  read data, port i at [i*DATA_W +: DATA_W]
rd_busy  out  NUM_RD  1 = register addressed by read port i is pending
wr_en  in  NUM_WR  write enable per write port
wr_addr  in  NUM_WR*AW  write addresses
wr_data  in  NUM_WR*DATA_W  write data
alloc_en  in  1  mark destination pending (issue)
alloc_addr  in  AW  destination to mark pending

Behaviour:
- Reset: when rst=1 at a rising edge, all registers are cleared to 0 and all pending bits are cleared. Writes and allocs in that cycle are discarded. rd_data/rd_busy are combinational, so after reset they read 0 and 0.
- Reads are combinational, 0-cycle latency: rd_data[i] = regs[rd_addr[i]] plus bypass.
- Writes commit at the rising edge when wr_en[j]=1. The value is visible through storage from the next cycle.
- Write conflict: two ports writing the same address in one cycle — the highest-index port wins, for both storage and bypass.
- Bypass (BYPASS=1): if any wr_en[j] && wr_addr[j]==rd_addr[i], rd_data[i] = winning wr_data in the same cycle. Also rd_busy[i] = 0 for that register, unless an alloc targets it in that cycle, in which case rd_busy[i] = 1.
- BYPASS=0: no forwarding; reads return pre-edge storage and the pre-edge pending bit.
- Scoreboard: pending[r] is set at the edge when alloc_en && alloc_addr==r. It is cleared at the edge when any write port writes r.
- Alloc and write to the same r in the same cycle: set wins (pending=1 after the edge). This models retiring an older instruction while a newer one claims r.
- Alloc to an already-pending register: stays 1, with no error indication.
- Write to a non-pending register: the data commits and pending stays 0 (legal).
- ZERO_REG=1, register 0:
  - writes are ignored, including bypass (reads always 0);
  - alloc is ignored and pending[0] is always 0.
- ZERO_REG=0: register 0 is an ordinary register.
- Out-of-range addresses are not possible (NUM_REGS is a power of 2).
- No X propagation on read outputs after reset.

Decomposition:
- Shared package cpu_pkg:
  - function reg_addr_w(n) = $clog2(n);
  - localparam defaults REG_DATA_W=32 and REG_COUNT=32, reused by decode and writeback.
- One sub-module: regfile_scoreboard. It holds the NUM_REGS pending bits and implements the set-wins rule and the zero-register masking. It takes clk, rst, alloc_en/alloc_addr, and wr_en/wr_addr, and exposes a pending vector.
- regfile_mp contains the storage array, write-priority logic and read/bypass muxes.

Test Plan:
- Reset then read ports 0..NUM_RD-1 at addresses 1, 2 -> rd_data=0, rd_busy=0. Write r5=0xDEADBEEF on port 0, read r5 next cycle -> 0xDEADBEEF.
- Same cycle: port0 writes r7=0x11, port1 writes r7=0x22 -> bypassed and stored r7 = 0x22 (highest index wins).
- BYPASS=1: write r3=0xA5A5A5A5 while reading r3 in the same cycle -> rd_data=0xA5A5A5A5 combinationally. Repeat with BYPASS=0 -> old value 0 that cycle, 0xA5A5A5A5 next cycle.
- Alloc r9 -> rd_busy=1 next cycle. Write r9=0x42 -> rd_busy=0 in the write cycle (bypass) and after. Alloc r9 and write r9 in the same cycle -> rd_busy=1 after the edge.
- ZERO_REG=1: write r0=0xFFFFFFFF and alloc r0 -> r0 reads 0, rd_busy=0 in both cycles. ZERO_REG=0: same stimulus -> reads 0xFFFFFFFF.
- Assert rst mid-operation with r4=0x1234 pending plus a concurrent write r4=0x99 -> after the edge r4=0 and pending clear, and the write is discarded.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU constants and helpers used by decode, writeback and the register file.
package cpu_pkg;

    localparam int unsigned REG_DATA_W = 32;
    localparam int unsigned REG_COUNT  = 32;

    // Address width needed to select one of n registers.
    function automatic int unsigned reg_addr_w(input int unsigned n);
        return $clog2(n);
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register pending bits: set by issue-time alloc, cleared by writeback.
// Alloc beats a same-cycle write to the same register; register 0 can be masked.
module regfile_scoreboard
    import cpu_pkg::*;
#(
    parameter int unsigned NUM_REGS = REG_COUNT,
    parameter int unsigned NUM_WR   = 2,
    parameter int unsigned ZERO_REG = 1,
    localparam int unsigned AW      = reg_addr_w(NUM_REGS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 alloc_en,
    input  logic [AW-1:0]        alloc_addr,
    input  logic [NUM_WR-1:0]    wr_en,
    input  logic [NUM_WR*AW-1:0] wr_addr,
    output logic [NUM_REGS-1:0]  pending
);

    localparam bit ZERO_EN = (ZERO_REG != 0);

    logic [NUM_REGS-1:0] pending_next;

    // Next pending vector: clears from every write port first, then the alloc set on top.
    always_comb begin
        pending_next = pending;
        for (int unsigned j = 0; j < NUM_WR; j++) begin
            if (wr_en[j]) begin
                pending_next[wr_addr[j*AW +: AW]] = 1'b0;
            end
        end
        if (alloc_en) begin
            pending_next[alloc_addr] = 1'b1;
        end
        if (ZERO_EN) begin
            pending_next[0] = 1'b0;
        end
    end

    // Pending state register with synchronous clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending <= '0;
        end else begin
            pending <= pending_next;
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file: NUM_RD combinational reads, NUM_WR writes with
// highest-port-wins priority, optional zero register, optional write bypass,
// and a pending scoreboard reported per read port.
module regfile_mp
    import cpu_pkg::*;
#(
    parameter int unsigned DATA_W   = REG_DATA_W,
    parameter int unsigned NUM_REGS = REG_COUNT,
    parameter int unsigned NUM_RD   = 2,
    parameter int unsigned NUM_WR   = 2,
    parameter int unsigned ZERO_REG = 1,
    parameter int unsigned BYPASS   = 1,
    localparam int unsigned AW      = reg_addr_w(NUM_REGS)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_RD*AW-1:0]     rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic [NUM_WR-1:0]        wr_en,
    input  logic [NUM_WR*AW-1:0]     wr_addr,
    input  logic [NUM_WR*DATA_W-1:0] wr_data,
    input  logic                     alloc_en,
    input  logic [AW-1:0]            alloc_addr
);

    localparam bit ZERO_EN = (ZERO_REG != 0);
    localparam bit BYP_EN  = (BYPASS != 0);

    logic [DATA_W-1:0]   regs [NUM_REGS];
    logic [NUM_REGS-1:0] pending;

    regfile_scoreboard #(
        .NUM_REGS (NUM_REGS),
        .NUM_WR   (NUM_WR),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .clk        (clk),
        .rst        (rst),
        .alloc_en   (alloc_en),
        .alloc_addr (alloc_addr),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .pending    (pending)
    );

    // Storage update; ports are visited in ascending order so the highest
    // enabled port's non-blocking assignment is the one that lands.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned k = 0; k < NUM_REGS; k++) begin
                regs[k] <= '0;
            end
        end else begin
            for (int unsigned j = 0; j < NUM_WR; j++) begin
                if (wr_en[j] && !(ZERO_EN && (wr_addr[j*AW +: AW] == '0))) begin
                    regs[wr_addr[j*AW +: AW]] <= wr_data[j*DATA_W +: DATA_W];
                end
            end
        end
    end

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [AW-1:0]     ra;
        logic              zr;
        logic              hit;
        logic [DATA_W-1:0] fwd;
        logic [DATA_W-1:0] data;
        logic              busy;

        assign ra = rd_addr[i*AW +: AW];

        // Read mux: zero register, then same-cycle forward, then storage/pending.
        always_comb begin
            zr  = ZERO_EN && (ra == '0);
            hit = 1'b0;
            fwd = '0;
            for (int unsigned j = 0; j < NUM_WR; j++) begin
                if (wr_en[j] && (wr_addr[j*AW +: AW] == ra)) begin
                    hit = 1'b1;
                    fwd = wr_data[j*DATA_W +: DATA_W];
                end
            end
            if (zr) begin
                data = '0;
                busy = 1'b0;
            end else if (BYP_EN && hit) begin
                // A forwarded write retires the register unless a new alloc claims it.
                data = fwd;
                busy = alloc_en && (alloc_addr == ra);
            end else begin
                data = regs[ra];
                busy = pending[ra];
            end
        end

        assign rd_data[i*DATA_W +: DATA_W] = data;
        assign rd_busy[i]                  = busy;
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: three instances (default, no bypass, no zero
// register) share stimulus; each has its own read outputs.
module tb_regfile_mp;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic [2*AW-1:0] rd_addr;
    logic [1:0]    wr_en;
    logic [2*AW-1:0] wr_addr;
    logic [2*DW-1:0] wr_data;
    logic          alloc_en;
    logic [AW-1:0] alloc_addr;

    logic [2*DW-1:0] d_def, d_nb, d_nz;
    logic [1:0]      b_def, b_nb, b_nz;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    regfile_mp #(.DATA_W(32), .NUM_REGS(32), .NUM_RD(2), .NUM_WR(2), .ZERO_REG(1), .BYPASS(1)) dut (
        .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(d_def), .rd_busy(b_def),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .alloc_en(alloc_en), .alloc_addr(alloc_addr));

    regfile_mp #(.DATA_W(32), .NUM_REGS(32), .NUM_RD(2), .NUM_WR(2), .ZERO_REG(1), .BYPASS(0)) dut_nb (
        .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(d_nb), .rd_busy(b_nb),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .alloc_en(alloc_en), .alloc_addr(alloc_addr));

    regfile_mp #(.DATA_W(32), .NUM_REGS(32), .NUM_RD(2), .NUM_WR(2), .ZERO_REG(0), .BYPASS(1)) dut_nz (
        .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(d_nz), .rd_busy(b_nz),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .alloc_en(alloc_en), .alloc_addr(alloc_addr));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr_en    = '0;
        wr_addr  = '0;
        wr_data  = '0;
        alloc_en = 1'b0;
        alloc_addr = '0;
    endtask

    task automatic wr(input int p, input logic [AW-1:0] a, input logic [31:0] d);
        wr_en[p] = 1'b1;
        wr_addr[p*AW +: AW] = a;
        wr_data[p*DW +: DW] = d;
    endtask

    task automatic rd(input int p, input logic [AW-1:0] a);
        rd_addr[p*AW +: AW] = a;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        rd_addr = '0;
        idle();
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        rd(0, 5'd1); rd(1, 5'd2); #1;
        chk("rst_d0", d_def[31:0], 32'h0);
        chk("rst_d1", d_def[63:32], 32'h0);
        chk("rst_b0", {31'b0, b_def[0]}, 32'h0);
        chk("rst_b1", {31'b0, b_def[1]}, 32'h0);

        // Simple write then read through storage
        wr(0, 5'd5, 32'hDEADBEEF);
        tick(); idle();
        rd(0, 5'd5); #1;
        chk("r5", d_def[31:0], 32'hDEADBEEF);

        // Dual-port write conflict: port 1 wins
        wr(0, 5'd7, 32'h11); wr(1, 5'd7, 32'h22); rd(0, 5'd7); #1;
        chk("r7_byp", d_def[31:0], 32'h22);
        chk("r7_nb_old", d_nb[31:0], 32'h0);
        tick(); idle(); #1;
        chk("r7_store", d_def[31:0], 32'h22);
        chk("r7_nb_store", d_nb[31:0], 32'h22);

        // Bypass vs. no bypass on read port 1
        wr(0, 5'd3, 32'hA5A5A5A5); rd(1, 5'd3); #1;
        chk("r3_byp", d_def[63:32], 32'hA5A5A5A5);
        chk("r3_nb_old", d_nb[63:32], 32'h0);
        tick(); idle(); #1;
        chk("r3_nb_new", d_nb[63:32], 32'hA5A5A5A5);

        // Scoreboard on r9
        alloc_en = 1'b1; alloc_addr = 5'd9; rd(0, 5'd9); #1;
        chk("r9_busy_pre", {31'b0, b_def[0]}, 32'h0);
        tick(); idle(); #1;
        chk("r9_busy", {31'b0, b_def[0]}, 32'h1);
        chk("r9_nb_busy", {31'b0, b_nb[0]}, 32'h1);
        wr(1, 5'd9, 32'h42); #1;
        chk("r9_wr_busy", {31'b0, b_def[0]}, 32'h0);
        chk("r9_nb_wr_busy", {31'b0, b_nb[0]}, 32'h1);
        chk("r9_wr_data", d_def[31:0], 32'h42);
        tick(); idle(); #1;
        chk("r9_after_busy", {31'b0, b_def[0]}, 32'h0);
        chk("r9_nb_after_busy", {31'b0, b_nb[0]}, 32'h0);
        chk("r9_after_data", d_def[31:0], 32'h42);
        alloc_en = 1'b1; alloc_addr = 5'd9; wr(0, 5'd9, 32'h43); #1;
        chk("r9_setwin_cur", {31'b0, b_def[0]}, 32'h1);
        chk("r9_setwin_data", d_def[31:0], 32'h43);
        tick(); idle(); #1;
        chk("r9_setwin_busy", {31'b0, b_def[0]}, 32'h1);
        chk("r9_nb_setwin_busy", {31'b0, b_nb[0]}, 32'h1);
        chk("r9_setwin_store", d_nb[31:0], 32'h43);

        // Register 0 behaviour
        wr(0, 5'd0, 32'hFFFFFFFF); alloc_en = 1'b1; alloc_addr = 5'd0; rd(0, 5'd0); #1;
        chk("r0_z_data", d_def[31:0], 32'h0);
        chk("r0_z_busy", {31'b0, b_def[0]}, 32'h0);
        chk("r0_nz_data", d_nz[31:0], 32'hFFFFFFFF);
        chk("r0_nz_busy", {31'b0, b_nz[0]}, 32'h1);
        tick(); idle(); #1;
        chk("r0_z_data2", d_def[31:0], 32'h0);
        chk("r0_z_busy2", {31'b0, b_def[0]}, 32'h0);
        chk("r0_nz_data2", d_nz[31:0], 32'hFFFFFFFF);
        chk("r0_nz_busy2", {31'b0, b_nz[0]}, 32'h1);

        // Reset mid-operation with r4 pending and a concurrent write
        wr(0, 5'd4, 32'h1234);
        tick(); idle();
        alloc_en = 1'b1; alloc_addr = 5'd4;
        tick(); idle();
        rd(0, 5'd4); #1;
        chk("r4_pend", {31'b0, b_def[0]}, 32'h1);
        chk("r4_val", d_def[31:0], 32'h1234);
        rst = 1'b1; wr(1, 5'd4, 32'h99);
        tick(); rst = 1'b0; idle(); #1;
        chk("r4_rst_data", d_def[31:0], 32'h0);
        chk("r4_rst_busy", {31'b0, b_def[0]}, 32'h0);
        rd(1, 5'd5); #1;
        chk("r5_rst", d_def[63:32], 32'h0);
        rd(0, 5'd0); #1;
        chk("r0_nz_rst", d_nz[31:0], 32'h0);
        chk("r0_nz_rst_busy", {31'b0, b_nz[0]}, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
